// File: rtl/quick_spi_pkg.sv
// Shared definitions for the quick_spi core and its command sequencer.
package quick_spi_pkg;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_EOT,
        S_RESPOND,
        S_GAP
    } seq_state_t;

    // Packed command word is {operation, slave, data}.
    function automatic int cmd_width(input int n_slaves, input int out_width);
        return 1 + n_slaves + out_width;
    endfunction

endpackage

// File: rtl/quick_spi_cmd_fifo.sv
// Single-clock command FIFO with occupancy output for the quick_spi sequencer.
module quick_spi_cmd_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (w_pop && !w_push) r_level <= r_level - 1'b1;
        end
    end

    // Storage is not reset; a reset simply discards it via the pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/quick_spi_sequencer.sv
// Command sequencer in front of the quick_spi master core.
// Optional watchdog: define QUICK_SPI_SEQUENCER_TIMEOUT_EN.
module quick_spi_sequencer
    import quick_spi_pkg::*;
#(
    parameter int NUMBER_OF_SLAVES    = 2,
    parameter int INCOMING_DATA_WIDTH = 8,
    parameter int OUTGOING_DATA_WIDTH = 16,
    parameter int FIFO_DEPTH          = 4,
    parameter int GAP_CYCLES          = 2,
    parameter int TIMEOUT_CYCLES      = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_operation,
    input  logic [NUMBER_OF_SLAVES-1:0]    cmd_slave,
    input  logic [OUTGOING_DATA_WIDTH-1:0] cmd_data,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [INCOMING_DATA_WIDTH-1:0] rsp_data,
    output logic                           rsp_timeout,
    output logic                           spi_enable,
    output logic                           spi_start,
    output logic [NUMBER_OF_SLAVES-1:0]    spi_slave,
    output logic                           spi_operation,
    output logic [OUTGOING_DATA_WIDTH-1:0] spi_outgoing_data,
    input  logic                           spi_end_of_transaction,
    input  logic [INCOMING_DATA_WIDTH-1:0] spi_incoming_data,
    output logic                           busy,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);
    localparam int CW = cmd_width(NUMBER_OF_SLAVES, OUTGOING_DATA_WIDTH);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    seq_state_t r_state;
    seq_state_t w_next_state;

    logic                           w_empty;
    logic                           w_full;
    logic                           w_pop;
    logic                           w_wdog_hit;
    logic                           w_eot_seen;
    logic [CW-1:0]                  w_head;
    logic                           r_op;
    logic [NUMBER_OF_SLAVES-1:0]    r_slave;
    logic [OUTGOING_DATA_WIDTH-1:0] r_data;
    logic                           r_rsp_valid;
    logic [INCOMING_DATA_WIDTH-1:0] r_rsp_data;
    logic [GW-1:0]                  r_gap_cnt;

    quick_spi_cmd_fifo #(
        .WIDTH (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (cmd_valid),
        .i_data  ({cmd_operation, cmd_slave, cmd_data}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign w_eot_seen = (r_state == S_WAIT_EOT) && spi_end_of_transaction;

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: w_next_state = S_WAIT_EOT;
            S_WAIT_EOT: begin
                if (spi_end_of_transaction)
                    w_next_state = (r_op == OP_READ) ? S_RESPOND : S_GAP;
                else if (w_wdog_hit)
                    w_next_state = S_RESPOND;
            end
            S_RESPOND: if (rsp_ready) w_next_state = S_GAP;
            S_GAP: if (r_gap_cnt == GAP_LAST) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op        <= 1'b0;
            r_slave     <= '0;
            r_data      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_gap_cnt   <= '0;
        end else begin
            if (w_pop) {r_op, r_slave, r_data} <= w_head;
            r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;
            if (w_eot_seen && r_op == OP_READ) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= spi_incoming_data;
            end else if (w_wdog_hit) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= '0;
            end else if (r_state == S_RESPOND && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef QUICK_SPI_SEQUENCER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_wdog;
    logic          r_rsp_timeout;

    assign w_wdog_hit = (r_state == S_WAIT_EOT) && !spi_end_of_transaction
                        && (r_wdog == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog        <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_wdog <= (r_state == S_WAIT_EOT) ? r_wdog + 1'b1 : '0;
            if (w_wdog_hit)
                r_rsp_timeout <= 1'b1;
            else if (r_state == S_RESPOND && rsp_ready)
                r_rsp_timeout <= 1'b0;
        end
    end

    assign rsp_timeout = r_rsp_timeout;
`else
    // No watchdog: a non-negative limit never fires, WAIT_EOT waits forever.
    assign w_wdog_hit  = (TIMEOUT_CYCLES < 0);
    assign rsp_timeout = 1'b0;
`endif

    assign cmd_ready         = !w_full;
    assign rsp_valid         = r_rsp_valid;
    assign rsp_data          = r_rsp_data;
    assign spi_enable        = !reset;
    assign spi_start         = (r_state == S_ISSUE);
    assign spi_operation     = r_op;
    assign spi_slave         = r_slave;
    assign spi_outgoing_data = r_data;
    assign busy              = (r_state != S_IDLE) || !w_empty;

endmodule
